kv_cache_append_wr: RTL

//  Upstream writer for the post-transpose HBM MVM stage (attention score Q*K^T in KV-cache mode).

---
 rtl/kv_cache_append_wr.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/kv_cache_append_wr.sv
// kv_cache_append_wr
//   Scatters the new token's per-head K/V pixels into the KV cache laid out as
//   [head][ch_blk][token], one AXI4 single-beat write per pixel. It pulses done
//   once every write has been B-responded, so a reader sees a consistent cache.
//
//   Beat (h,c) lands at base + h*head_strd + c*surf_strd + token*PIX_BYTES.
//   The address is built with adders only: row_addr steps by surf_strd per beat
//   and head_addr steps by head_strd when c wraps.
//
//   AXI fixed fields are constants for the wrapper to tie: awlen=0,
//   awsize=log2(DATA_W/8), awburst=INCR, wstrb all-ones, wlast=1.
//
// Optional build macro: KV_APPEND_BRESP_CHK_EN
//   defined   : a counted B with bresp!=OKAY sets err_o. err_o stays set until
//               the next accepted start or reset; the transfer still completes.
//   undefined : err_o is 0 and m_bresp_i is ignored.
//
// Ports
//   clk_i, rst_n_i          clock, async active-low reset
//   start_i, cfg_*_i        job start pulse and config (latched in IDLE only)
//   s_valid_i/s_ready_o/s_data_i   pixel stream, ch_blk fastest then head
//   m_aw*_o/m_awready_i     AXI write address channel
//   m_w*_o/m_wready_i       AXI write data channel
//   m_b*_i/m_bready_o       AXI write response channel
//   busy_o, done_o, err_o   status
module kv_cache_append_wr #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_head_strd_i,
  input  logic [ADDR_W-1:0] cfg_surf_strd_i,
  input  logic [CNT_W-1:0]  cfg_token_i,
  input  logic [CNT_W-1:0]  cfg_heads_i,
  input  logic [CNT_W-1:0]  cfg_ch_blks_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PIX_SH = $clog2(DATA_W / 8);
  localparam int OW     = $clog2(MAX_OUTST) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] head_strd_q, head_strd_d;
  logic [ADDR_W-1:0] surf_strd_q, surf_strd_d;
  logic [CNT_W-1:0]  heads_q, heads_d;
  logic [CNT_W-1:0]  ch_blks_q, ch_blks_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  c_q, c_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              err_q, err_d;
  logic              bready_q;

  logic              accept;
  logic              b_fire;
  logic [ADDR_W-1:0] tok_off;
  logic [ADDR_W-1:0] next_head;

  assign tok_off   = ADDR_W'(cfg_token_i) << PIX_SH;
  assign next_head = head_addr_q + head_strd_q;

  // One beat in flight per channel: a new pixel waits until both AW and W
  // of the previous one have completed.
  assign s_ready_o = (state_q == RUN) & ~awvalid_q & ~wvalid_q &
                     (outst_q < OW'(MAX_OUTST));
  assign accept    = s_valid_i & s_ready_o;
  // Stray responses with nothing outstanding are dropped.
  assign b_fire    = m_bvalid_i & bready_q & (outst_q != '0);

  always_comb begin
    state_d     = state_q;
    head_strd_d = head_strd_q;
    surf_strd_d = surf_strd_q;
    heads_d     = heads_q;
    ch_blks_d   = ch_blks_q;
    h_d         = h_q;
    c_d         = c_q;
    head_addr_d = head_addr_q;
    row_addr_d  = row_addr_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    outst_d     = outst_q;
    err_d       = err_q;

    if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
    if (wvalid_q && m_wready_i)   wvalid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          head_strd_d = cfg_head_strd_i;
          surf_strd_d = cfg_surf_strd_i;
          heads_d     = cfg_heads_i;
          ch_blks_d   = cfg_ch_blks_i;
          h_d         = '0;
          c_d         = '0;
          head_addr_d = cfg_base_i + tok_off;
          row_addr_d  = cfg_base_i + tok_off;
          err_d       = 1'b0;
          state_d     = (cfg_heads_i == '0 || cfg_ch_blks_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          awaddr_d  = row_addr_q;
          wdata_d   = s_data_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          if (c_q == ch_blks_q - 1'b1) begin
            c_d         = '0;
            h_d         = h_q + 1'b1;
            head_addr_d = next_head;
            row_addr_d  = next_head;
            if (h_q == heads_q - 1'b1) state_d = DRAIN;
          end else begin
            c_d        = c_q + 1'b1;
            row_addr_d = row_addr_q + surf_strd_q;
          end
        end
      end
      DRAIN: begin
        if (outst_q == '0 && !awvalid_q && !wvalid_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case ({accept, b_fire})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

`ifdef KV_APPEND_BRESP_CHK_EN
    if (b_fire && m_bresp_i != 2'b00) err_d = 1'b1;
`endif
  end

`ifndef KV_APPEND_BRESP_CHK_EN
  logic unused_bresp;
  assign unused_bresp = ^m_bresp_i;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      head_strd_q <= '0;
      surf_strd_q <= '0;
      heads_q     <= '0;
      ch_blks_q   <= '0;
      h_q         <= '0;
      c_q         <= '0;
      head_addr_q <= '0;
      row_addr_q  <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      outst_q     <= '0;
      err_q       <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_strd_q <= head_strd_d;
      surf_strd_q <= surf_strd_d;
      heads_q     <= heads_d;
      ch_blks_q   <= ch_blks_d;
      h_q         <= h_d;
      c_q         <= c_d;
      head_addr_q <= head_addr_d;
      row_addr_q  <= row_addr_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
      bready_q    <= 1'b1;
    end
  end

  assign m_awaddr_o  = awaddr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;
  // busy covers the done cycle; both drop together on the return to IDLE.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule
